// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the fetch PC sequencer slice.
//   PC_XLEN      default address width
//   PC_STEP      default sequential increment in bytes (power of two)
//   PC_RAS_DEPTH default return-address-stack depth
//   addr_t       address type at the default width
//   next_src_e   where the next pc0 comes from in a given cycle
// Optional feature macro used by the slice: PC_RAS_EN (return-address stack).
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam int PC_XLEN      = 32;
  localparam int PC_STEP      = 4;
  localparam int PC_RAS_DEPTH = 4;

  typedef logic [PC_XLEN-1:0] addr_t;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_TRAP,
    SRC_RAS,
    SRC_HOLD
  } next_src_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the request and status signals between the fetch control logic
// (master) and the PC sequencer (slave).
//   stall, we, write_addr, trap_we, trap_addr,
//   ras_push, ras_push_addr, ras_pop          : master -> slave
//   pc0, pc4, misalign, ras_empty, ras_full   : slave -> master
// Parameter XLEN sets the address width of the bundle.
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int XLEN = pc_pkg::PC_XLEN
);

  logic            stall;
  logic            we;
  logic [XLEN-1:0] write_addr;
  logic            trap_we;
  logic [XLEN-1:0] trap_addr;
  logic            ras_push;
  logic [XLEN-1:0] ras_push_addr;
  logic            ras_pop;
  logic [XLEN-1:0] pc0;
  logic [XLEN-1:0] pc4;
  logic            misalign;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, we, write_addr, trap_we, trap_addr,
           ras_push, ras_push_addr, ras_pop,
    input  pc0, pc4, misalign, ras_empty, ras_full
  );

  modport slave (
    input  stall, we, write_addr, trap_we, trap_addr,
           ras_push, ras_push_addr, ras_pop,
    output pc0, pc4, misalign, ras_empty, ras_full
  );

endinterface

// File: rtl/pc_ras_stack.sv
// ---------------------------------------------------------------------------
// pc_ras_stack
// Circular return-address stack with a top pointer and a saturating count.
// A push on a full stack overwrites the oldest entry. A pop on an empty stack
// is ignored. Push and pop together replace the top entry in place.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_push        push request (already qualified by the caller)
//   i_pop         pop request (already qualified by the caller)
//   i_clear       drop all entries
//   i_push_addr   address to push
//   o_top         current top entry (meaningful only when not empty)
//   o_empty       no entries held
//   o_full        RAS_DEPTH entries held
// ---------------------------------------------------------------------------
module pc_ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_push_addr,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty,
  output logic            o_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_tp;
  logic [CW-1:0]   r_cnt;

  logic [PW-1:0]   w_tp_inc;
  logic [PW-1:0]   w_tp_dec;
  logic            w_pop_ok;
  logic            w_push_only;

  // Explicit wrap so depths that are not powers of two still work.
  assign w_tp_inc    = (r_tp == LAST_IDX) ? '0 : r_tp + 1'b1;
  assign w_tp_dec    = (r_tp == '0) ? LAST_IDX : r_tp - 1'b1;
  assign w_pop_ok    = i_pop && (r_cnt != '0);
  assign w_push_only = i_push && !w_pop_ok;

  assign o_top   = r_mem[r_tp];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FULL_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tp  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (w_push_only) begin
      // Pointer keeps advancing when full, so the oldest slot is reused.
      r_tp <= w_tp_inc;
      if (r_cnt != FULL_CNT) r_cnt <= r_cnt + 1'b1;
    end else if (w_pop_ok && !i_push) begin
      r_tp  <= w_tp_dec;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage carries no reset; only the pointer and count need one.
  always_ff @(posedge clk) begin
    if (!rst && !i_clear && i_push) begin
      r_mem[w_push_only ? w_tp_inc : r_tp] <= i_push_addr;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Fetch PC register holding the current PC (pc0) and its sequential
// successor (pc4). Per-cycle priority: rst > trap_we > stall > we > ras_pop >
// sequential. Redirect targets have their low bits cleared to STEP alignment;
// misalign pulses for one cycle when an accepted target was not aligned.
// All outputs come from flops (or the RAS count/storage), never directly
// from inputs.
// Optional feature: define PC_RAS_EN to include the return-address stack.
// Without it ras_push/ras_pop are ignored, ras_empty=1 and ras_full=0.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        pc_sequencer_if.slave (requests in, pc0/pc4/status out)
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = PC_XLEN,
  parameter int              STEP         = PC_STEP,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = PC_RAS_DEPTH
) (
  input logic               clk,
  input logic               rst,
  pc_sequencer_if.slave     bus
);

  localparam logic [XLEN-1:0] STEP_A     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [XLEN-1:0] RESET_PC4  = RESET_VECTOR + STEP_A;

  logic [XLEN-1:0] r_pc0;
  logic [XLEN-1:0] r_pc4;
  logic            r_misalign;

  next_src_e       w_src;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_tgt_al;
  logic            w_tgt_mis;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_pop_ok;

`ifdef PC_RAS_EN
  logic w_ras_push;
  logic w_ras_pop;

  // Stall or trap drop stack requests; the trap itself empties the stack.
  assign w_ras_push = bus.ras_push && !bus.stall && !bus.trap_we;
  assign w_ras_pop  = bus.ras_pop  && !bus.stall && !bus.trap_we;
  assign w_pop_ok   = bus.ras_pop && !w_ras_empty;

  pc_ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_ras_push),
    .i_pop       (w_ras_pop),
    .i_clear     (bus.trap_we),
    .i_push_addr (bus.ras_push_addr),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (w_ras_full)
  );
`else
  logic w_unused;

  assign w_unused    = ^{bus.ras_push, bus.ras_push_addr, bus.ras_pop};
  assign w_pop_ok    = 1'b0;
  assign w_ras_top   = '0;
  assign w_ras_empty = 1'b1;
  assign w_ras_full  = 1'b0;
`endif

  always_comb begin
    w_src = SRC_SEQ;
    if (bus.trap_we)   w_src = SRC_TRAP;
    else if (bus.stall) w_src = SRC_HOLD;
    else if (bus.we)    w_src = SRC_BRANCH;
    else if (w_pop_ok)  w_src = SRC_RAS;
  end

  assign w_tgt     = bus.trap_we ? bus.trap_addr : bus.write_addr;
  assign w_tgt_al  = w_tgt & ~ALIGN_MASK;
  assign w_tgt_mis = |(w_tgt & ALIGN_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc0      <= RESET_VECTOR;
      r_pc4      <= RESET_PC4;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (w_src)
        SRC_TRAP, SRC_BRANCH: begin
          r_pc0      <= w_tgt_al;
          r_pc4      <= w_tgt_al + STEP_A;
          r_misalign <= w_tgt_mis;
        end
        SRC_RAS: begin
          r_pc0 <= w_ras_top;
          r_pc4 <= w_ras_top + STEP_A;
        end
        SRC_HOLD: begin
          r_pc0 <= r_pc0;
          r_pc4 <= r_pc4;
        end
        default: begin
          r_pc0 <= r_pc4;
          r_pc4 <= r_pc4 + STEP_A;
        end
      endcase
    end
  end

  assign bus.pc0       = r_pc0;
  assign bus.pc4       = r_pc4;
  assign bus.misalign  = r_misalign;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_full  = w_ras_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Table-driven directed vectors, hand-written return-stack sequences and a
// randomized run against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h100;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(32)) bif ();

  pc_sequencer #(
    .XLEN         (32),
    .STEP         (4),
    .RESET_VECTOR (RV),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: plain PC values plus a queue as the stack.
  addr_t m_pc0, m_pc4;
  logic  m_mis;
  addr_t m_ras[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_step();
    addr_t top;
    bit    pop_ok;
    if (rst) begin
      m_pc0 = RV; m_pc4 = RV + 4; m_mis = 0; m_ras.delete();
    end else if (bif.trap_we) begin
      m_pc0 = bif.trap_addr & ~32'h3;
      m_pc4 = m_pc0 + 4;
      m_mis = (bif.trap_addr % 4) != 0;
      m_ras.delete();
    end else if (bif.stall) begin
      m_mis = 0;
    end else begin
      m_mis  = 0;
      pop_ok = RAS_ON && bif.ras_pop && (m_ras.size() > 0);
      top    = pop_ok ? m_ras[$] : '0;
      if (bif.we) begin
        m_pc0 = bif.write_addr & ~32'h3;
        m_pc4 = m_pc0 + 4;
        m_mis = (bif.write_addr % 4) != 0;
      end else if (pop_ok) begin
        m_pc0 = top;
        m_pc4 = top + 4;
      end else begin
        m_pc0 = m_pc4;
        m_pc4 = m_pc4 + 4;
      end
      if (RAS_ON) begin
        if (bif.ras_push && pop_ok) m_ras[m_ras.size()-1] = bif.ras_push_addr;
        else if (bif.ras_push) begin
          m_ras.push_back(bif.ras_push_addr);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (pop_ok) void'(m_ras.pop_back());
      end
    end
  endfunction

  task automatic cyc(input logic r, input logic s, input logic w, input logic [31:0] wa,
                     input logic t, input logic [31:0] ta,
                     input logic pu, input logic [31:0] pa, input logic po);
    rst = r; bif.stall = s; bif.we = w; bif.write_addr = wa;
    bif.trap_we = t; bif.trap_addr = ta;
    bif.ras_push = pu; bif.ras_push_addr = pa; bif.ras_pop = po;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc0"},   bif.pc0, m_pc0);
    chk({tag, ".pc4"},   bif.pc4, m_pc4);
    chk({tag, ".mis"},   32'(bif.misalign), 32'(m_mis));
    chk({tag, ".empty"}, 32'(bif.ras_empty), 32'(m_ras.size() == 0));
    chk({tag, ".full"},  32'(bif.ras_full), 32'(RAS_ON && m_ras.size() == DEPTH));
  endtask

  typedef struct {
    logic        rst, stall, we;
    logic [31:0] wa;
    logic        trap;
    logic [31:0] ta;
    logic [31:0] e_pc0, e_pc4;
    logic        e_mis;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, stall vs redirect, alignment and wrap.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h100,      32'h104,  1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h100,      32'h104,  1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h104,      32'h108,  1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h108,      32'h10C,  1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 32'h0,   32'h108,      32'h10C,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h40,       1'b1, 32'h80,  32'h80,       32'h84,   1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h43,       1'b0, 32'h0,   32'h40,       32'h44,   1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h44,       32'h48,   1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,   32'hFFFFFFFC, 32'h0,    1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        32'h4,    1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h206, 32'h204,      32'h208,  1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   32'h204,      32'h208,  1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h1000,     1'b0, 32'h0,   32'h1000,     32'h1004, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rst, tbl[i].stall, tbl[i].we, tbl[i].wa, tbl[i].trap, tbl[i].ta, 1'b0, 32'h0, 1'b0);
      chk($sformatf("tbl%0d.pc0", i), bif.pc0, tbl[i].e_pc0);
      chk($sformatf("tbl%0d.pc4", i), bif.pc4, tbl[i].e_pc4);
      chk($sformatf("tbl%0d.mis", i), 32'(bif.misalign), 32'(tbl[i].e_mis));
      chk($sformatf("tbl%0d.empty", i), 32'(bif.ras_empty), 32'd1);
    end

`ifdef PC_RAS_EN
    // Fill past capacity: oldest entry 0x10 is overwritten.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 0, 0, 0, 1, 32'(i * 16), 0);
    chk("ras.full", 32'(bif.ras_full), 32'd1);
    chk("ras.notempty", 32'(bif.ras_empty), 32'd0);
    chk("ras.seqpc", bif.pc0, 32'h114);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk($sformatf("ras.pop%0d", i), bif.pc0, 32'h50 - 32'(i * 16));
    end
    chk("ras.empty", 32'(bif.ras_empty), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ras.pop_empty", bif.pc0, 32'h24);
    // Push and pop together replace the top in place.
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h10, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h20, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h90, 1);
    chk("ras.pushpop", bif.pc0, 32'h20);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ras.newtop", bif.pc0, 32'h90);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ras.bottom", bif.pc0, 32'h10);
    // Pop alongside a branch: branch wins, pop still consumed.
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h30, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h34, 0);
    cyc(0, 0, 1, 32'h500, 0, 0, 0, 0, 1);
    chk("ras.we_pop", bif.pc0, 32'h500);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ras.after_we_pop", bif.pc0, 32'h30);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h30, 0);
    cyc(0, 0, 0, 0, 1, 32'h200, 0, 0, 0);
    chk("ras.trap_clear", 32'(bif.ras_empty), 32'd1);
    chk("ras.trap_pc", bif.pc0, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h44, 0);
`endif
    // Reset during a stall wins on the next edge.
    cyc(0, 1, 1, 32'h700, 0, 0, 1, 32'h48, 1);
    cyc(1, 1, 1, 32'h700, 0, 0, 1, 32'h48, 1);
    chk("rst_mid.pc0", bif.pc0, 32'h100);
    chk("rst_mid.pc4", bif.pc4, 32'h104);
    chk("rst_mid.empty", 32'(bif.ras_empty), 32'd1);
    chk("rst_mid.full", 32'(bif.ras_full), 32'd0);
    chk_model("rst_mid");

    // Randomized run against the reference model.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] wa, ta, pa;
      wa = $urandom;
      ta = $urandom;
      pa = $urandom;
      if ($urandom_range(0, 1) == 0) wa[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) wa = 32'hFFFFFFF0 | (wa & 32'hF);
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, wa,
          $urandom_range(0, 15) == 0, ta, $urandom_range(0, 3) == 0, pa, $urandom_range(0, 3) == 0);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
